alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameters: none; all widths are fixed by this document.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid_i  input  1  instruction word present.
REQ-005 instr_ready_o  output  1  block accepts instruction; transfer when valid&ready at clk edge.
REQ-006 instr_i  input  16  [15:13] op, [12:11] rd, [10:9] rs1, [8] imm_sel, [7:0] imm8 (imm_sel=1) or [1:0] rs2 (imm_sel=0).
REQ-007 alu_op_o  output  3  op to external combinational ALU: 000 ADD, 001 SUB, 010 SLL by b[2:0], 011 SRL by b[2:0], 100 AND, 101 OR, 110 XOR, 111 EQL ({7'b0, a==b}).
REQ-008 alu_a_o  output  8  ALU operand A.
REQ-009 alu_b_o  output  8  ALU operand B.
REQ-010 alu_res_i  input  8  ALU result, combinational function of alu_op_o/alu_a_o/alu_b_o.
REQ-011 res_valid_o  output  1  write-back result available.
REQ-012 res_ready_i  input  1  consumer takes result; transfer when valid&ready at clk edge.
REQ-013 res_data_o  output  8  result value.
REQ-014 res_rd_o  output  2  destination register of result.

Function
REQ-015 Internal register file: 4 x 8-bit, r0..r3, all writable (r0 not hard-wired).
REQ-016 FSM states IDLE, EXEC, RESP; all outputs registered or decoded from state only.
REQ-017 IDLE: instr_ready_o=1; on instr_valid_i&instr_ready_o, register op -> alu_op_o, rf[rs1] -> alu_a_o, (imm_sel ? imm8 : rf[rs2]) -> alu_b_o, rd internally; go EXEC; else stay IDLE.
REQ-018 Operands are read from rf at the accept edge; rd==rs1/rs2 uses the pre-write value.
REQ-019 EXEC (exactly 1 cycle): instr_ready_o=0; at end of cycle sample alu_res_i into res_data_o and rf[rd], rd into res_rd_o; go RESP.
REQ-020 RESP: res_valid_o=1, instr_ready_o=0; res_data_o/res_rd_o stable while res_valid_o&!res_ready_i; on res_ready_i go IDLE with res_valid_o=0 next cycle.
REQ-021 alu_op_o/alu_a_o/alu_b_o hold their last values outside EXEC; only EXEC values are meaningful.
REQ-022 Latency: accept edge N -> res_valid_o high in cycle N+2; minimum issue interval 3 cycles with res_ready_i held 1.
REQ-023 rf write at EXEC exit is visible to an instruction accepted in the following IDLE cycle (no stale read).
REQ-024 All arithmetic 8-bit modulo 256; carries/borrows discarded by the ALU, not by this block.
REQ-025 instr_i ignored when instr_ready_o=0; instr_valid_i held high never causes double accept.

Reset
REQ-026 reset sampled high at clk edge: state=IDLE, rf all 0x00, res_valid_o=0, res_data_o=0x00, res_rd_o=0, alu_op_o=000, alu_a_o=0x00, alu_b_o=0x00, instr_ready_o=0 while reset is high.
REQ-027 reset in EXEC or RESP aborts the instruction: no rf write, no res_valid_o pulse; instr_ready_o=1 first cycle after reset deasserts.

Verification
REQ-028 Bench connects a combinational ALU model implementing REQ-007 encoding to alu_* ports.
REQ-029 After reset, ADD rd=1 rs1=0 imm=0x05 accepted cycle N -> res_valid_o=1 cycle N+2, res_data_o=0x05, res_rd_o=1.
REQ-030 Chain: ADD r1=r0+imm 0x05; ADD r2=r1+imm 0x03 -> 0x08; SUB r3=r1-r2 (register) -> 0xFD; EQL r0=r3 vs imm 0xFD -> 0x01.
REQ-031 SLL r1=r1(0x81 via ADD imm) by imm 0x09 -> b[2:0]=1 -> 0x02; SRL 0x80 by imm 0x07 -> 0x01.
REQ-032 res_ready_i low 5 cycles in RESP -> res_valid_o=1, res_data_o/res_rd_o unchanged, instr_ready_o=0 throughout; single transfer when ready rises.
REQ-033 reset pulsed during EXEC of ADD r1 imm 0x44 -> no res_valid_o; next ADD r2=r1+imm 0x00 returns 0x00.
REQ-034 instr_valid_i held 1 with 4 distinct instructions, res_ready_i=1 -> accepts exactly every 3 cycles, 4 results in order, none duplicated or dropped.

Source files
------------

// File: rtl/alu_issue.sv
// Single-issue front end for an external combinational ALU: decodes one
// instruction at a time against a 4 x 8-bit register file and returns the result.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [15:0] instr_i,
    output logic [2:0]  alu_op_o,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    input  logic [7:0]  alu_res_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [7:0]  res_data_o,
    output logic [1:0]  res_rd_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rf [4];
    logic [1:0] rd_q;
    logic       accept;

    logic [2:0] dec_op;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs1;
    logic [1:0] dec_rs2;
    logic       dec_imm_sel;
    logic [7:0] dec_imm8;

    assign dec_op      = instr_i[15:13];
    assign dec_rd      = instr_i[12:11];
    assign dec_rs1     = instr_i[10:9];
    assign dec_imm_sel = instr_i[8];
    assign dec_imm8    = instr_i[7:0];
    assign dec_rs2     = instr_i[1:0];

    // Ready is masked by reset so nothing can be accepted while reset is held.
    assign instr_ready_o = (state == IDLE) && !reset;
    assign res_valid_o   = (state == RESP);
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rf         <= '{default: '0};
            alu_op_o   <= '0;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            rd_q       <= '0;
            res_data_o <= '0;
            res_rd_o   <= '0;
        end else begin
            state <= state_nxt;
            // Operands come from rf at the accept edge, before any pending write.
            if (accept) begin
                alu_op_o <= dec_op;
                alu_a_o  <= rf[dec_rs1];
                alu_b_o  <= dec_imm_sel ? dec_imm8 : rf[dec_rs2];
                rd_q     <= dec_rd;
            end
            if (state == EXEC) begin
                res_data_o <= alu_res_i;
                res_rd_o   <= rd_q;
                rf[rd_q]   <= alu_res_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed bench for alu_issue with a combinational ALU model
// and a transaction-level register-file reference.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_res;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rf_m [4];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .alu_op_o      (alu_op),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_res_i     (alu_res),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_data_o    (res_data),
        .res_rd_o      (res_rd)
    );

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a << b[2:0];
            3'd3: r = a >> b[2:0];
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return r;
    endfunction

    assign alu_res = alu_fn(alu_op, alu_a, alu_b);

    function automatic logic [15:0] mk_imm(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [7:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [15:0] mk_reg(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, 1'b0, 6'b0, rs2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_operands(input logic [15:0] ins, output logic [7:0] a, output logic [7:0] b);
        a = rf_m[ins[10:9]];
        b = ins[8] ? ins[7:0] : rf_m[ins[1:0]];
    endtask

    // Full transaction: accept, check EXEC, then RESP with 'hold' cycles of backpressure.
    task automatic do_instr(input logic [15:0] ins, input int hold, output logic [7:0] got);
        logic [7:0] a, b, exp;
        int t;
        model_operands(ins, a, b);
        exp = alu_fn(ins[15:13], a, b);
        instr_valid = 1'b1;
        instr = ins;
        t = 0;
        while (!instr_ready && t < 20) begin
            tick;
            t++;
        end
        chk("ready_wait", {31'b0, instr_ready}, 32'd1);
        tick;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        chk("exec_ready", {31'b0, instr_ready}, 32'd0);
        chk("exec_valid", {31'b0, res_valid}, 32'd0);
        chk("exec_op", {29'b0, alu_op}, {29'b0, ins[15:13]});
        chk("exec_a", {24'b0, alu_a}, {24'b0, a});
        chk("exec_b", {24'b0, alu_b}, {24'b0, b});
        res_ready = (hold == 0);
        tick;
        got = res_data;
        chk("resp_valid", {31'b0, res_valid}, 32'd1);
        chk("resp_data", {24'b0, res_data}, {24'b0, exp});
        chk("resp_rd", {30'b0, res_rd}, {30'b0, ins[12:11]});
        for (int k = 1; k < hold; k++) begin
            tick;
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", {24'b0, res_data}, {24'b0, exp});
            chk("hold_rd", {30'b0, res_rd}, {30'b0, ins[12:11]});
            chk("hold_ready", {31'b0, instr_ready}, 32'd0);
        end
        res_ready = 1'b1;
        tick;
        chk("post_valid", {31'b0, res_valid}, 32'd0);
        chk("post_ready", {31'b0, instr_ready}, 32'd1);
        rf_m[ins[12:11]] = exp;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick;
        tick;
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_data", {24'b0, res_data}, 32'd0);
        chk("rst_rd", {30'b0, res_rd}, 32'd0);
        chk("rst_op", {29'b0, alu_op}, 32'd0);
        chk("rst_a", {24'b0, alu_a}, 32'd0);
        chk("rst_b", {24'b0, alu_b}, 32'd0);
        rf_m = '{default: 8'h00};
        reset = 1'b0;
        #1;
        chk("rst_exit_ready", {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        logic [15:0] stream [4];
        logic [7:0] sa, sb, sexp;

        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        res_ready = 1'b1;
        apply_reset;

        // First instruction latency and value
        do_instr(mk_imm(3'd0, 2'd1, 2'd0, 8'h05), 0, got);
        chk("first_add", {24'b0, got}, 32'h05);

        // Dependency chain
        do_instr(mk_imm(3'd0, 2'd2, 2'd1, 8'h03), 0, got);
        chk("chain_add", {24'b0, got}, 32'h08);
        do_instr(mk_reg(3'd1, 2'd3, 2'd1, 2'd2), 0, got);
        chk("chain_sub", {24'b0, got}, 32'hFD);
        do_instr(mk_imm(3'd7, 2'd0, 2'd3, 8'hFD), 0, got);
        chk("chain_eql", {24'b0, got}, 32'h01);

        // Shifts use only b[2:0]
        do_instr(mk_imm(3'd4, 2'd0, 2'd0, 8'h00), 0, got);
        do_instr(mk_imm(3'd0, 2'd1, 2'd0, 8'h81), 0, got);
        do_instr(mk_imm(3'd2, 2'd1, 2'd1, 8'h09), 0, got);
        chk("sll_wrap", {24'b0, got}, 32'h02);
        do_instr(mk_imm(3'd0, 2'd2, 2'd0, 8'h80), 0, got);
        do_instr(mk_imm(3'd3, 2'd2, 2'd2, 8'h07), 0, got);
        chk("srl", {24'b0, got}, 32'h01);

        // Backpressure for 5 cycles
        do_instr(mk_imm(3'd6, 2'd3, 2'd1, 8'h5A), 5, got);
        chk("bp_xor", {24'b0, got}, 32'h58);

        // Reset during EXEC aborts
        instr_valid = 1'b1;
        instr = mk_imm(3'd0, 2'd1, 2'd0, 8'h44);
        tick;
        instr_valid = 1'b0;
        chk("abort_exec_ready", {31'b0, instr_ready}, 32'd0);
        reset = 1'b1;
        tick;
        chk("abort_ready_in_rst", {31'b0, instr_ready}, 32'd0);
        chk("abort_valid", {31'b0, res_valid}, 32'd0);
        reset = 1'b0;
        rf_m = '{default: 8'h00};
        #1;
        chk("abort_exit_ready", {31'b0, instr_ready}, 32'd1);
        tick;
        chk("abort_no_pulse", {31'b0, res_valid}, 32'd0);
        do_instr(mk_imm(3'd0, 2'd2, 2'd1, 8'h00), 0, got);
        chk("abort_no_write", {24'b0, got}, 32'h00);

        // Streaming with valid held high: one accept every 3 cycles
        stream[0] = mk_imm(3'd0, 2'd0, 2'd0, 8'h11);
        stream[1] = mk_imm(3'd0, 2'd1, 2'd0, 8'h22);
        stream[2] = mk_reg(3'd5, 2'd2, 2'd0, 2'd1);
        stream[3] = mk_reg(3'd1, 2'd3, 2'd2, 2'd0);
        res_ready = 1'b1;
        instr_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            instr = stream[j];
            chk("stream_ready", {31'b0, instr_ready}, 32'd1);
            model_operands(stream[j], sa, sb);
            sexp = alu_fn(stream[j][15:13], sa, sb);
            tick;
            instr = (j < 3) ? stream[j + 1] : 16'hFFFF;
            chk("stream_exec_ready", {31'b0, instr_ready}, 32'd0);
            chk("stream_exec_a", {24'b0, alu_a}, {24'b0, sa});
            chk("stream_exec_b", {24'b0, alu_b}, {24'b0, sb});
            tick;
            chk("stream_valid", {31'b0, res_valid}, 32'd1);
            chk("stream_data", {24'b0, res_data}, {24'b0, sexp});
            chk("stream_rd", {30'b0, res_rd}, {30'b0, stream[j][12:11]});
            chk("stream_resp_ready", {31'b0, instr_ready}, 32'd0);
            rf_m[stream[j][12:11]] = sexp;
            if (j < 3) begin
                tick;
                chk("stream_idle_valid", {31'b0, res_valid}, 32'd0);
            end
        end
        instr_valid = 1'b0;
        tick;
        chk("stream_end_valid", {31'b0, res_valid}, 32'd0);
        chk("stream_end_ready", {31'b0, instr_ready}, 32'd1);

        // Randomized instructions with random backpressure
        for (int n = 0; n < 60; n++) begin
            logic [15:0] ins;
            if ($urandom_range(0, 1) == 1)
                ins = mk_imm(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 8'($urandom));
            else
                ins = mk_reg(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom));
            do_instr(ins, int'($urandom_range(0, 3)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
